// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: everything that flows from the memory-access stage into
// the MEM/WB register, and the registered writeback signals leaving it.
//   slave  : the MEM/WB stage side (consumes MEM inputs, drives wb_* and mem_busy)
//   master : the upstream/register-file side (drives MEM inputs, observes wb_*)
// Inputs  : flush, mem_en_0/1, ld_en_0/1, valid_0/1, rd_we_0/1, rd_0/1,
//           alu_0/1, dc_rdata
// Outputs : wb_valid_0/1, wb_we_0/1, wb_rd_0/1, wb_data_0/1, mem_busy
interface mem_wb_stage_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_AW     = 5
);
    logic                  flush;
    logic                  mem_en_0;
    logic                  mem_en_1;
    logic                  ld_en_0;
    logic                  ld_en_1;
    logic                  valid_0;
    logic                  valid_1;
    logic                  rd_we_0;
    logic                  rd_we_1;
    logic [REG_AW-1:0]     rd_0;
    logic [REG_AW-1:0]     rd_1;
    logic [DATA_WIDTH-1:0] alu_0;
    logic [DATA_WIDTH-1:0] alu_1;
    logic [DATA_WIDTH-1:0] dc_rdata;

    logic                  wb_valid_0;
    logic                  wb_valid_1;
    logic                  wb_we_0;
    logic                  wb_we_1;
    logic [REG_AW-1:0]     wb_rd_0;
    logic [REG_AW-1:0]     wb_rd_1;
    logic [DATA_WIDTH-1:0] wb_data_0;
    logic [DATA_WIDTH-1:0] wb_data_1;
    logic                  mem_busy;

    modport slave (
        input  flush, mem_en_0, mem_en_1, ld_en_0, ld_en_1, valid_0, valid_1,
               rd_we_0, rd_we_1, rd_0, rd_1, alu_0, alu_1, dc_rdata,
        output wb_valid_0, wb_valid_1, wb_we_0, wb_we_1, wb_rd_0, wb_rd_1,
               wb_data_0, wb_data_1, mem_busy
    );

    modport master (
        output flush, mem_en_0, mem_en_1, ld_en_0, ld_en_1, valid_0, valid_1,
               rd_we_0, rd_we_1, rd_0, rd_1, alu_0, alu_1, dc_rdata,
        input  wb_valid_0, wb_valid_1, wb_we_0, wb_we_1, wb_rd_0, wb_rd_1,
               wb_data_0, wb_data_1, mem_busy
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Dual-issue MEM/WB pipeline register.
// Picks the writeback value per slot (D-cache data for loads, ALU result
// otherwise), re-pairs the two-cycle serialized access that happens when both
// slots use the single D-cache port, suppresses writes to x0 and the older
// slot's write on a same-destination collision, and counts retirements.
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   bus        : mem_wb_stage_if.slave (MEM inputs in, wb_* and mem_busy out)
//   retire_cnt : retired-instruction count, wraps modulo 2^CNT_WIDTH
module mem_wb_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned CNT_WIDTH  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_wb_stage_if.slave        bus,
    output logic [CNT_WIDTH-1:0] retire_cnt
);
    typedef enum logic {FIRST, SECOND} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_we;
    logic [REG_AW-1:0]     hold_rd;

    logic                  v0_q, v1_q, we0_q, we1_q;
    logic [REG_AW-1:0]     rd0_q, rd1_q;
    logic [DATA_WIDTH-1:0] data0_q, data1_q;

    logic [DATA_WIDTH-1:0] res_0, res_1;
    logic                  we_0, we_1, dual;
    logic [DATA_WIDTH-1:0] nxt0_data;
    logic                  nxt0_we;
    logic [REG_AW-1:0]     nxt0_rd;
    logic                  waw;

    assign res_0 = bus.ld_en_0 ? bus.dc_rdata : bus.alu_0;
    assign res_1 = bus.ld_en_1 ? bus.dc_rdata : bus.alu_1;
    assign we_0  = bus.valid_0 & bus.rd_we_0 & (bus.rd_0 != '0);
    assign we_1  = bus.valid_1 & bus.rd_we_1 & (bus.rd_1 != '0);
    assign dual  = bus.mem_en_0 & bus.mem_en_1 & bus.valid_0 & bus.valid_1 & ~bus.flush;

    // Slot 0's next output comes from the hold register in SECOND and from the
    // live inputs otherwise; the collision check must use whichever applies.
    always_comb begin
        nxt0_data = res_0;
        nxt0_we   = we_0;
        nxt0_rd   = bus.rd_0;
        if (state == SECOND) begin
            nxt0_data = hold_data;
            nxt0_we   = hold_we;
            nxt0_rd   = hold_rd;
        end
        waw = nxt0_we & we_1 & (nxt0_rd == bus.rd_1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FIRST;
            hold_data  <= '0;
            hold_we    <= 1'b0;
            hold_rd    <= '0;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            we0_q      <= 1'b0;
            we1_q      <= 1'b0;
            rd0_q      <= '0;
            rd1_q      <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
            retire_cnt <= '0;
        end else begin
            retire_cnt <= retire_cnt + CNT_WIDTH'(v0_q) + CNT_WIDTH'(v1_q);
            if (bus.flush) begin
                v0_q      <= 1'b0;
                v1_q      <= 1'b0;
                we0_q     <= 1'b0;
                we1_q     <= 1'b0;
                hold_data <= '0;
                hold_we   <= 1'b0;
                hold_rd   <= '0;
                state     <= FIRST;
            end else if (state == FIRST && dual) begin
                // First half of a serialized access: park slot 0, emit a bubble.
                hold_data <= res_0;
                hold_we   <= we_0;
                hold_rd   <= bus.rd_0;
                v0_q      <= 1'b0;
                v1_q      <= 1'b0;
                we0_q     <= 1'b0;
                we1_q     <= 1'b0;
                state     <= SECOND;
            end else begin
                // Normal issue, or second half where dc_rdata belongs to slot 1.
                // A held slot 0 was necessarily valid when captured.
                v0_q    <= (state == SECOND) ? 1'b1 : bus.valid_0;
                we0_q   <= nxt0_we & ~waw;
                rd0_q   <= nxt0_rd;
                data0_q <= nxt0_data;
                v1_q    <= bus.valid_1;
                we1_q   <= we_1;
                rd1_q   <= bus.rd_1;
                data1_q <= res_1;
                state   <= FIRST;
            end
        end
    end

    assign bus.wb_valid_0 = v0_q;
    assign bus.wb_valid_1 = v1_q;
    assign bus.wb_we_0    = we0_q;
    assign bus.wb_we_1    = we1_q;
    assign bus.wb_rd_0    = rd0_q;
    assign bus.wb_rd_1    = rd1_q;
    assign bus.wb_data_0  = data0_q;
    assign bus.wb_data_1  = data1_q;
    assign bus.mem_busy   = (state == SECOND);
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage, built with a 4-bit retire counter so
// that counter wrap-around is reachable in a short run.
module tb_mem_wb_stage;
    logic       clk;
    logic       rst_n;
    logic [3:0] retire_cnt;

    mem_wb_stage_if #(.DATA_WIDTH(32), .REG_AW(5)) bus ();

    mem_wb_stage #(.DATA_WIDTH(32), .REG_AW(5), .CNT_WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v0, v1, me0, me1, ld0, ld1, rw0, rw1;
        logic [4:0]  rd0, rd1;
        logic [31:0] alu0, alu1, dc;
        logic        ev0, ev1, ewe0, ewe1;
        logic [4:0]  erd0, erd1;
        logic [31:0] ed0, ed1;
    } vec_t;

    vec_t vecs [8];

    int unsigned n_total;
    int unsigned n_pass;
    logic [3:0]  cnt_exp;
    logic        prev_v0, prev_v1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // One clock edge; model the counter, which accumulates the previous
    // cycle's registered valids.
    task automatic tick(input logic ev0, input logic ev1);
        @(posedge clk);
        #1;
        cnt_exp = cnt_exp + 4'(prev_v0) + 4'(prev_v1);
        prev_v0 = ev0;
        prev_v1 = ev1;
    endtask

    task automatic check_ctl(input string tag, input logic ev0, input logic ev1,
                             input logic ewe0, input logic ewe1, input logic ebusy);
        chk({tag, "_valid0"}, 32'(bus.wb_valid_0), 32'(ev0));
        chk({tag, "_valid1"}, 32'(bus.wb_valid_1), 32'(ev1));
        chk({tag, "_we0"},    32'(bus.wb_we_0),    32'(ewe0));
        chk({tag, "_we1"},    32'(bus.wb_we_1),    32'(ewe1));
        chk({tag, "_busy"},   32'(bus.mem_busy),   32'(ebusy));
        chk({tag, "_cnt"},    32'(retire_cnt),     32'(cnt_exp));
    endtask

    task automatic drive(input vec_t v);
        bus.valid_0  = v.v0;   bus.valid_1  = v.v1;
        bus.mem_en_0 = v.me0;  bus.mem_en_1 = v.me1;
        bus.ld_en_0  = v.ld0;  bus.ld_en_1  = v.ld1;
        bus.rd_we_0  = v.rw0;  bus.rd_we_1  = v.rw1;
        bus.rd_0     = v.rd0;  bus.rd_1     = v.rd1;
        bus.alu_0    = v.alu0; bus.alu_1    = v.alu1;
        bus.dc_rdata = v.dc;
    endtask

    task automatic idle();
        bus.valid_0 = 1'b0;  bus.valid_1 = 1'b0;
        bus.mem_en_0 = 1'b0; bus.mem_en_1 = 1'b0;
        bus.ld_en_0 = 1'b0;  bus.ld_en_1 = 1'b0;
        bus.rd_we_0 = 1'b0;  bus.rd_we_1 = 1'b0;
        bus.rd_0 = 5'd0;     bus.rd_1 = 5'd0;
        bus.alu_0 = 32'h0;   bus.alu_1 = 32'h0;
        bus.dc_rdata = 32'h0;
    endtask

    task automatic dual_load(input logic [4:0] r0, input logic [4:0] r1, input logic [31:0] d);
        bus.valid_0 = 1'b1;  bus.valid_1 = 1'b1;
        bus.mem_en_0 = 1'b1; bus.mem_en_1 = 1'b1;
        bus.ld_en_0 = 1'b1;  bus.ld_en_1 = 1'b1;
        bus.rd_we_0 = 1'b1;  bus.rd_we_1 = 1'b1;
        bus.rd_0 = r0;       bus.rd_1 = r1;
        bus.alu_0 = 32'hA0;  bus.alu_1 = 32'hA1;
        bus.dc_rdata = d;
    endtask

    task automatic alu_slot0(input logic [4:0] r0, input logic [31:0] a);
        idle();
        bus.valid_0 = 1'b1;
        bus.rd_we_0 = 1'b1;
        bus.rd_0    = r0;
        bus.alu_0   = a;
    endtask

    task automatic model_reset();
        cnt_exp = 4'd0;
        prev_v0 = 1'b0;
        prev_v1 = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        model_reset();
        // {v0,v1,me0,me1,ld0,ld1,rw0,rw1, rd0,rd1, alu0,alu1,dc,
        //  ev0,ev1,ewe0,ewe1, erd0,erd1, ed0,ed1}
        vecs[0] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1, 5'd5,5'd7, 32'h0,32'h55,32'hDEADBEEF,
                    1'b1,1'b0,1'b1,1'b0, 5'd5,5'd7, 32'hDEADBEEF,32'h55};
        vecs[1] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 5'd0,5'd3, 32'h7,32'h100,32'h999,
                    1'b1,1'b1,1'b0,1'b0, 5'd0,5'd3, 32'h7,32'h100};
        vecs[2] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 5'd9,5'd9, 32'h1,32'h2,32'h0,
                    1'b1,1'b1,1'b0,1'b1, 5'd9,5'd9, 32'h1,32'h2};
        vecs[3] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1, 5'd2,5'd12, 32'h33,32'h44,32'hCAFE,
                    1'b1,1'b1,1'b1,1'b1, 5'd2,5'd12, 32'h33,32'hCAFE};
        vecs[4] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 5'd1,5'd2, 32'hA,32'hB,32'h0,
                    1'b0,1'b0,1'b0,1'b0, 5'd1,5'd2, 32'hA,32'hB};
        vecs[5] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 5'd6,5'd7, 32'h10,32'h20,32'h0,
                    1'b1,1'b1,1'b1,1'b1, 5'd6,5'd7, 32'h10,32'h20};
        vecs[6] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 5'd8,5'd8, 32'h5,32'h6,32'h77,
                    1'b1,1'b0,1'b0,1'b0, 5'd8,5'd8, 32'h77,32'h6};
        vecs[7] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 5'd9,5'd9, 32'h3,32'h4,32'h0,
                    1'b1,1'b0,1'b1,1'b0, 5'd9,5'd9, 32'h3,32'h4};

        rst_n = 1'b0;
        bus.flush = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_data0", bus.wb_data_0, 32'h0);
        chk("reset_rd1", 32'(bus.wb_rd_1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i]);
            tick(vecs[i].ev0, vecs[i].ev1);
            check_ctl($sformatf("vec%0d", i), vecs[i].ev0, vecs[i].ev1, vecs[i].ewe0, vecs[i].ewe1, 1'b0);
            chk($sformatf("vec%0d_rd0", i), 32'(bus.wb_rd_0), 32'(vecs[i].erd0));
            chk($sformatf("vec%0d_rd1", i), 32'(bus.wb_rd_1), 32'(vecs[i].erd1));
            chk($sformatf("vec%0d_data0", i), bus.wb_data_0, vecs[i].ed0);
            chk($sformatf("vec%0d_data1", i), bus.wb_data_1, vecs[i].ed1);
        end

        // Dual load: bubble, then both slots together.
        dual_load(5'd3, 5'd4, 32'h11);
        tick(1'b0, 1'b0);
        check_ctl("dual_a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.dc_rdata = 32'h22;
        tick(1'b1, 1'b1);
        check_ctl("dual_b", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("dual_b_data0", bus.wb_data_0, 32'h11);
        chk("dual_b_data1", bus.wb_data_1, 32'h22);
        chk("dual_b_rd0", 32'(bus.wb_rd_0), 32'd3);
        chk("dual_b_rd1", 32'(bus.wb_rd_1), 32'd4);

        // Dual load to the same destination: held slot 0 loses the write.
        dual_load(5'd3, 5'd3, 32'h33);
        tick(1'b0, 1'b0);
        check_ctl("dwaw_a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.dc_rdata = 32'h44;
        tick(1'b1, 1'b1);
        check_ctl("dwaw_b", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("dwaw_b_data0", bus.wb_data_0, 32'h33);
        chk("dwaw_b_data1", bus.wb_data_1, 32'h44);

        // Flush wins over entering SECOND.
        dual_load(5'd5, 5'd6, 32'h55);
        bus.flush = 1'b1;
        tick(1'b0, 1'b0);
        check_ctl("flush_first", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush while in SECOND.
        bus.flush = 1'b0;
        tick(1'b0, 1'b0);
        check_ctl("fl2_a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.flush = 1'b1;
        tick(1'b0, 1'b0);
        check_ctl("fl2_b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.flush = 1'b0;
        alu_slot0(5'd6, 32'h66);
        tick(1'b1, 1'b0);
        check_ctl("fl2_after", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("fl2_after_data0", bus.wb_data_0, 32'h66);

        // Asynchronous reset with live outputs.
        rst_n = 1'b0;
        #1;
        model_reset();
        check_ctl("arst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("arst_data0", bus.wb_data_0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while in SECOND drops the held result.
        dual_load(5'd7, 5'd8, 32'h77);
        tick(1'b0, 1'b0);
        check_ctl("rst2_a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_ctl("rst2_b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        alu_slot0(5'd10, 32'hAB);
        tick(1'b1, 1'b0);
        check_ctl("rst2_after", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst2_after_data0", bus.wb_data_0, 32'hAB);

        // Counter wrap with a 4-bit counter: reach 15, then retire 2 -> 1.
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(vecs[5]);
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b1);
        alu_slot0(5'd4, 32'h1);
        tick(1'b1, 1'b0);
        drive(vecs[5]);
        tick(1'b1, 1'b1);
        chk("wrap_15", 32'(retire_cnt), 32'd15);
        idle();
        tick(1'b0, 1'b0);
        chk("wrap_1", 32'(retire_cnt), 32'd1);
        check_ctl("wrap_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
